// File: rtl/culsans_exit_monitor.sv
// Passive end-of-test monitor on the slave-side AXI port: captures the exit-register write.
// Optional watchdog enabled by defining CULSANS_EXIT_MONITOR_WATCHDOG_EN.

package culsans_pkg;
  localparam logic [63:0] exitAddr = 64'h0000_0000_8000_0000;
  localparam int unsigned IdWidth  = 8;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [63:0]        addr;
    logic [7:0]         len;
    logic [2:0]         size;
    logic [1:0]         burst;
    logic [5:0]         atop;
  } aw_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } b_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    logic     ar_valid;
    logic     r_ready;
  } req_slv_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    logic    r_valid;
  } resp_slv_t;
endpackage

module culsans_exit_monitor #(
  parameter int unsigned AW_FIFO_DEPTH   = 8,
  parameter logic [63:0] EXIT_ADDR       = culsans_pkg::exitAddr,
  parameter logic [31:0] WATCHDOG_CYCLES = 32'd1_000_000
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [$bits(culsans_pkg::req_slv_t)-1:0]  axi_req_i,
  input  logic [$bits(culsans_pkg::resp_slv_t)-1:0] axi_resp_i,
  output logic                                    exit_valid_o,
  output logic                                    exit_pass_o,
  output logic [30:0]                             exit_code_o,
  output logic                                    error_o,
  output logic                                    timeout_o
);

  localparam int unsigned PtrW = $clog2(AW_FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StWaitW, StWaitB, StDone} state_e;

  culsans_pkg::req_slv_t  req;
  culsans_pkg::resp_slv_t rsp;

  assign req = axi_req_i;
  assign rsp = axi_resp_i;

  state_e                            state_q;
  logic [AW_FIFO_DEPTH-1:0]          fifo_exit_q;
  logic [PtrW-1:0]                   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]                   count_q;
  logic                              first_beat_q;
  logic [culsans_pkg::IdWidth-1:0]   exit_id_q;
  logic [31:0]                       exit_data_q;
  logic                              exit_valid_q, exit_pass_q, error_q;
  logic [30:0]                       exit_code_q;

  logic aw_hs, w_hs, b_hs;
  logic fifo_empty, fifo_full, push, pop, aw_is_exit;
  logic capture, b_exit, err_set;

  always_comb begin
    aw_hs      = req.aw_valid & rsp.aw_ready;
    w_hs       = req.w_valid & rsp.w_ready;
    b_hs       = rsp.b_valid & req.b_ready;
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CntW'(AW_FIFO_DEPTH));
    push       = aw_hs & ~fifo_full;
    pop        = w_hs & req.w.last & ~fifo_empty;
    aw_is_exit = (req.aw.addr == EXIT_ADDR) & (req.aw.atop == '0) & (state_q == StIdle);
    // Only the first beat of the burst at the FIFO head can carry the exit value.
    capture    = w_hs & first_beat_q & ~fifo_empty & fifo_exit_q[rd_ptr_q] &
                 (state_q == StWaitW);
    b_exit     = b_hs & (state_q == StWaitB) & (rsp.b.id == exit_id_q);
    err_set    = (aw_hs & fifo_full) | (w_hs & fifo_empty) |
                 (capture & (req.w.strb[3:0] != 4'hF)) | (b_exit & (rsp.b.resp != 2'b00));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      fifo_exit_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      first_beat_q <= 1'b1;
      exit_id_q    <= '0;
      exit_data_q  <= '0;
      exit_valid_q <= 1'b0;
      exit_pass_q  <= 1'b0;
      exit_code_q  <= '0;
      error_q      <= 1'b0;
    end else begin
      if (push) begin
        fifo_exit_q[wr_ptr_q] <= aw_is_exit;
        wr_ptr_q              <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CntW'(1);
      end
      if (w_hs) begin
        first_beat_q <= req.w.last;
      end
      if (err_set) begin
        error_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (push && aw_is_exit) begin
            exit_id_q <= req.aw.id;
            state_q   <= StWaitW;
          end
        end
        StWaitW: begin
          if (capture) begin
            exit_data_q <= req.w.data[31:0];
            state_q     <= StWaitB;
          end
        end
        StWaitB: begin
          if (b_exit) begin
            exit_valid_q <= 1'b1;
            exit_code_q  <= exit_data_q[31:1];
            exit_pass_q  <= (exit_data_q == 32'd1);
            state_q      <= StDone;
          end
        end
        StDone: ;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign exit_valid_o = exit_valid_q;
  assign exit_pass_o  = exit_pass_q;
  assign exit_code_o  = exit_code_q;
  assign error_o      = error_q;

`ifdef CULSANS_EXIT_MONITOR_WATCHDOG_EN
  logic [31:0] wd_cnt_q;
  logic        timeout_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else if (!exit_valid_q && (wd_cnt_q != WATCHDOG_CYCLES)) begin
      wd_cnt_q <= wd_cnt_q + 32'd1;
      if (wd_cnt_q + 32'd1 == WATCHDOG_CYCLES) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_wd;
  assign unused_wd = ^WATCHDOG_CYCLES;
  assign timeout_o = 1'b0;
`endif

  // Only a subset of the observed bus fields matters to the monitor.
  logic unused_bus;
  assign unused_bus = ^{axi_req_i, axi_resp_i};

endmodule

// File: tb/tb_culsans_exit_monitor.sv
// Scoreboard bench for culsans_exit_monitor: expected exit reports are queued when the
// exit data beat is driven and compared when exit_valid_o rises.

module tb_culsans_exit_monitor;

  typedef struct packed {
    logic        pass;
    logic [30:0] code;
    logic        err;
  } exp_t;

  logic clk, rst_ni;
  culsans_pkg::req_slv_t  req;
  culsans_pkg::resp_slv_t rsp;
  logic        exit_valid, exit_pass, error, timeout;
  logic [30:0] exit_code;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  localparam logic [63:0] Exit = 64'h0000_0000_8000_0000;

  culsans_exit_monitor #(
    .AW_FIFO_DEPTH  (8),
    .EXIT_ADDR      (Exit),
    .WATCHDOG_CYCLES(32'd100)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .axi_req_i   (req),
    .axi_resp_i  (rsp),
    .exit_valid_o(exit_valid),
    .exit_pass_o (exit_pass),
    .exit_code_o (exit_code),
    .error_o     (error),
    .timeout_o   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    req    = '0;
    rsp    = '0;
    rst_ni = 1'b0;
    @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  task automatic aw_beat(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len);
    req.aw       = '0;
    req.aw.id    = id;
    req.aw.addr  = addr;
    req.aw.len   = len;
    req.aw_valid = 1'b1;
    rsp.aw_ready = 1'b1;
    @(posedge clk);
    #1 req.aw_valid = 1'b0;
    rsp.aw_ready = 1'b0;
  endtask

  task automatic w_beat(input logic [63:0] data, input logic [7:0] strb, input logic last);
    req.w.data  = data;
    req.w.strb  = strb;
    req.w.last  = last;
    req.w_valid = 1'b1;
    rsp.w_ready = 1'b1;
    @(posedge clk);
    #1 req.w_valid = 1'b0;
    rsp.w_ready = 1'b0;
  endtask

  task automatic b_beat(input logic [7:0] id, input logic [1:0] resp);
    rsp.b.id    = id;
    rsp.b.resp  = resp;
    rsp.b_valid = 1'b1;
    req.b_ready = 1'b1;
    @(posedge clk);
    #1 rsp.b_valid = 1'b0;
    req.b_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++; if (exit_valid !== 1'b0) begin n_miss++; $display("FAIL rst_valid: got %b want 0", exit_valid); end
    n_vec++; if (exit_pass !== 1'b0) begin n_miss++; $display("FAIL rst_pass: got %b want 0", exit_pass); end
    n_vec++; if (exit_code !== 31'd0) begin n_miss++; $display("FAIL rst_code: got %h want 0", exit_code); end
    n_vec++; if (error !== 1'b0) begin n_miss++; $display("FAIL rst_error: got %b want 0", error); end
    n_vec++; if (timeout !== 1'b0) begin n_miss++; $display("FAIL rst_timeout: got %b want 0", timeout); end
  endtask

  task automatic test_exit_pass();
    exp_t e;
    apply_reset();
    aw_beat(8'd3, Exit, 8'd0);
    exp_q.push_back('{pass: 1'b1, code: 31'd0, err: 1'b0});
    w_beat(64'h1, 8'hFF, 1'b1);
    b_beat(8'd7, 2'b00);
    n_vec++; if (exit_valid !== 1'b0) begin n_miss++; $display("FAIL pass_other_id: valid got %b want 0", exit_valid); end
    b_beat(8'd3, 2'b00);
    n_vec++; if (exit_valid !== 1'b1) begin n_miss++; $display("FAIL pass_valid: got %b want 1", exit_valid); end
    e = exp_q.pop_front();
    n_vec++; if (exit_pass !== e.pass) begin n_miss++; $display("FAIL pass_pass: got %b want %b", exit_pass, e.pass); end
    n_vec++; if (exit_code !== e.code) begin n_miss++; $display("FAIL pass_code: got %h want %h", exit_code, e.code); end
    n_vec++; if (error !== e.err) begin n_miss++; $display("FAIL pass_error: got %b want %b", error, e.err); end
    // A second exit write after DONE must not disturb the captured result.
    aw_beat(8'd3, Exit, 8'd0);
    w_beat(64'h5, 8'hFF, 1'b1);
    b_beat(8'd3, 2'b00);
    n_vec++; if (exit_code !== 31'd0 || exit_pass !== 1'b1) begin
      n_miss++; $display("FAIL pass_hold: code %h pass %b want 0/1", exit_code, exit_pass);
    end
  endtask

  task automatic test_fail_code();
    exp_t e;
    apply_reset();
    aw_beat(8'd1, 64'h8004_0000, 8'd3);
    aw_beat(8'd5, Exit, 8'd0);
    for (int i = 0; i < 4; i++) w_beat(64'hDEAD_0000 + 64'(i), 8'hFF, i == 3);
    exp_q.push_back('{pass: 1'b0, code: 31'h0A, err: 1'b0});
    w_beat(64'h15, 8'hFF, 1'b1);
    b_beat(8'd1, 2'b00);
    n_vec++; if (exit_valid !== 1'b0) begin n_miss++; $display("FAIL code_early: valid got %b want 0", exit_valid); end
    b_beat(8'd5, 2'b00);
    n_vec++; if (exit_valid !== 1'b1) begin n_miss++; $display("FAIL code_valid: got %b want 1", exit_valid); end
    e = exp_q.pop_front();
    n_vec++; if (exit_pass !== e.pass) begin n_miss++; $display("FAIL code_pass: got %b want %b", exit_pass, e.pass); end
    n_vec++; if (exit_code !== e.code) begin n_miss++; $display("FAIL code_code: got %h want %h", exit_code, e.code); end
    n_vec++; if (error !== e.err) begin n_miss++; $display("FAIL code_error: got %b want %b", error, e.err); end
  endtask

  task automatic test_bad_resp();
    exp_t e;
    apply_reset();
    aw_beat(8'd2, Exit, 8'd0);
    exp_q.push_back('{pass: 1'b1, code: 31'd0, err: 1'b1});
    w_beat(64'h1, 8'hFF, 1'b1);
    n_vec++; if (error !== 1'b0) begin n_miss++; $display("FAIL resp_pre_err: got %b want 0", error); end
    b_beat(8'd2, 2'b10);
    n_vec++; if (exit_valid !== 1'b1) begin n_miss++; $display("FAIL resp_valid: got %b want 1", exit_valid); end
    e = exp_q.pop_front();
    n_vec++; if (exit_pass !== e.pass) begin n_miss++; $display("FAIL resp_pass: got %b want %b", exit_pass, e.pass); end
    n_vec++; if (error !== e.err) begin n_miss++; $display("FAIL resp_error: got %b want %b", error, e.err); end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 8; i++) aw_beat(8'(i), 64'h1000, 8'd0);
    n_vec++; if (error !== 1'b0) begin n_miss++; $display("FAIL ovf_full: error got %b want 0", error); end
    aw_beat(8'd9, 64'h1000, 8'd0);
    n_vec++; if (error !== 1'b1) begin n_miss++; $display("FAIL ovf_ninth: error got %b want 1", error); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    apply_reset();
    w_beat(64'h1, 8'hFF, 1'b1);
    n_vec++; if (error !== 1'b1) begin n_miss++; $display("FAIL orphan_w: error got %b want 1", error); end
    aw_beat(8'd4, Exit, 8'd0);
    rst_ni = 1'b0;
    #1;
    n_vec++; if ({exit_valid, exit_pass, exit_code, error} !== 34'd0) begin
      n_miss++; $display("FAIL mid_rst_outs: got %h want 0", {exit_valid, exit_pass, exit_code, error});
    end
    @(posedge clk);
    #1 rst_ni = 1'b1;
    aw_beat(8'd6, Exit, 8'd0);
    exp_q.push_back('{pass: 1'b1, code: 31'd0, err: 1'b0});
    w_beat(64'h1, 8'hFF, 1'b1);
    b_beat(8'd6, 2'b00);
    n_vec++; if (exit_valid !== 1'b1) begin n_miss++; $display("FAIL mid_valid: got %b want 1", exit_valid); end
    e = exp_q.pop_front();
    n_vec++; if (exit_pass !== e.pass) begin n_miss++; $display("FAIL mid_pass: got %b want %b", exit_pass, e.pass); end
    n_vec++; if (error !== e.err) begin n_miss++; $display("FAIL mid_error: got %b want %b", error, e.err); end
  endtask

  task automatic test_watchdog();
    apply_reset();
`ifdef CULSANS_EXIT_MONITOR_WATCHDOG_EN
    repeat (99) @(posedge clk);
    #1;
    n_vec++; if (timeout !== 1'b0) begin n_miss++; $display("FAIL wd_early: got %b want 0", timeout); end
    @(posedge clk);
    #1;
    n_vec++; if (timeout !== 1'b1) begin n_miss++; $display("FAIL wd_fire: got %b want 1", timeout); end
    repeat (5) @(posedge clk);
    #1;
    n_vec++; if (timeout !== 1'b1) begin n_miss++; $display("FAIL wd_sticky: got %b want 1", timeout); end
    apply_reset();
    aw_beat(8'd3, Exit, 8'd0);
    w_beat(64'h1, 8'hFF, 1'b1);
    b_beat(8'd3, 2'b00);
`endif
    repeat (150) @(posedge clk);
    #1;
    n_vec++; if (timeout !== 1'b0) begin n_miss++; $display("FAIL wd_quiet: got %b want 0", timeout); end
  endtask

  initial begin
    req    = '0;
    rsp    = '0;
    rst_ni = 1'b0;
    test_reset();
    test_exit_pass();
    test_fail_code();
    test_bad_resp();
    test_overflow();
    test_reset_mid();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/culsans_exit_monitor.md
Name: culsans_exit_monitor

Overview:
- Passive observer on the slave-side ACE/AXI port between the crossbar and the DRAM slave (req_slv_t / resp_slv_t).
- Detects the end-of-test write to the exit address and captures the written value once the write completes with OKAY.
- Reports pass/fail and any protocol anomalies.
- Never drives the bus.

Parameters:
- AW_FIFO_DEPTH, 8: accepted-AW bursts tracked while awaiting their W data; power of two, ≥2.
- EXIT_ADDR, culsans_pkg::exitAddr: 64-bit byte address of the exit register.
- WATCHDOG_CYCLES, 32'd1_000_000: timeout limit; used only with the optional feature.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- axi_req_i  in  $bits(culsans_pkg::req_slv_t)  observed request struct.
- axi_resp_i  in  $bits(culsans_pkg::resp_slv_t)  observed response struct.
- exit_valid_o  out  1  exit write completed; sticky.
- exit_pass_o  out  1  captured value == 32'd1; valid only while exit_valid_o=1.
- exit_code_o  out  31  captured value bits [31:1].
- error_o  out  1  sticky protocol/monitor error.
- timeout_o  out  1  watchdog expired; sticky; tied 0 without the feature.

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, first-beat flag = 1.
- Handshakes:
  - AW_hs = aw_valid & aw_ready; W_hs = w_valid & w_ready; B_hs = b_valid & b_ready.
  - Sampled only on the edge.
- AW FIFO:
  - On AW_hs, push flag is_exit = (aw.addr == EXIT_ADDR) & (aw.atop == 0) & (state == IDLE).
  - When is_exit=1, also latch exit_id = aw.id and go to WAIT_W.
  - On W_hs with w.last=1, pop.
  - Same-cycle push and pop: both occur and the count is unchanged.
  - Push when full: drop the entry and set error_o.
  - W_hs when empty, including the same cycle as the first push: set error_o and do not capture data. The crossbar guarantees AW precedes W on this port.
- First-beat flag:
  - Cleared on W_hs with last=0.
  - Set on W_hs with last=1.
- Capture: on W_hs with first-beat=1, FIFO head is_exit=1 and state WAIT_W:
  - exit_data <= w.data[31:0].
  - If w.strb[3:0] != 4'hF, set error_o.
  - Go to WAIT_B.
- State machine:
  - IDLE -> WAIT_W: exit AW accepted.
  - WAIT_W -> WAIT_B: capture.
  - WAIT_B -> DONE: B_hs with b.id == exit_id.
  - DONE: terminal until reset.
  - If b.resp != OKAY at the WAIT_B -> DONE transition, set error_o (still go to DONE).
- DONE outputs:
  - exit_valid_o = 1 in the cycle after the terminating B_hs.
  - exit_code_o = exit_data[31:1]; exit_pass_o = (exit_data == 1).
  - All three are registered and hold until reset.
- Non-exit traffic:
  - Exit-address AWs outside IDLE are treated as ordinary traffic (only the first exit is captured).
  - B responses with other IDs are ignored.
- Reset mid-operation: asynchronous clear of everything, including sticky flags and FIFO pointers.
- Width rules:
  - FIFO count is $clog2(AW_FIFO_DEPTH)+1 bits.
  - Pointers wrap modulo AW_FIFO_DEPTH.

Optional Feature:
- Macro: CULSANS_EXIT_MONITOR_WATCHDOG_EN.
- Defined:
  - 32-bit counter increments every cycle while exit_valid_o=0, saturating at WATCHDOG_CYCLES.
  - timeout_o is set in the cycle the count reaches WATCHDOG_CYCLES, sticky.
  - Counter freezes once exit_valid_o=1.
- Undefined: no counter logic; timeout_o tied 0; WATCHDOG_CYCLES unused.

Test Plan:
- Exit pass: AW addr=0x8000_0000 id=3 len=0; W data=0x1 strb=0xFF last=1; B id=3 OKAY -> exit_valid_o=1 one cycle after B, exit_pass_o=1, exit_code_o=0, error_o=0.
- Fail code behind traffic: AW 0x8004_0000 len=3 then exit AW id=5; 4 filler beats then data=0x0000_0015; B id=5 OKAY -> exit_code_o=0xA, exit_pass_o=0.
- Bad response: exit write with B resp=SLVERR -> exit_valid_o=1, error_o=1.
- FIFO overflow: 9 AW handshakes with no W, AW_FIFO_DEPTH=8 -> error_o=1 on the 9th.
- Reset mid-operation: exit AW accepted, then rst_ni=0 for 1 cycle -> all outputs 0; a later complete exit write reports normally.
- Watchdog (macro defined, WATCHDOG_CYCLES=100): no traffic -> timeout_o=1 at cycle 100 after reset release; an exit completed before cycle 100 -> timeout_o stays 0.
